load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 173 +++++++++++++++++
 tb/tb_load_store_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Byte/half/word load-store engine that turns a single pipeline
//               access into one or two aligned 32-bit memory beats, handling
//               misaligned accesses, lane positioning and load extension.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
   parameter logic [31:0] RESP_ERR_DATA = 32'hDEADC0DE
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_size,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

   state_t      state_q, state_d;
   logic        we_q;
   logic [2:0]  size_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        beat_q;       // 0 = first beat, 1 = second beat
   logic [31:0] rdata0_q;     // first-beat read data of a split load
   logic [31:0] rsp_rdata_q;
   logic        rsp_err_q;

   logic [1:0]  w_off;
   logic [3:0]  w_nmask;
   logic [2:0]  w_nbytes;
   logic        w_two;
   logic        w_last;
   logic [7:0]  w_mask;
   logic [63:0] w_data64;
   logic [31:0] w_base;
   logic [63:0] w_rd64;
   logic [31:0] w_shift;
   logic [31:0] w_ext;
   logic        w_in_req;
   logic        w_req_legal;

   // Legal funct3 codes: stores only B/H/W, loads additionally BU/HU.
   function automatic logic f_legal(input logic we, input logic [2:0] sz);
      if (we) return (sz == 3'b000) || (sz == 3'b001) || (sz == 3'b010);
      else    return (sz == 3'b000) || (sz == 3'b001) || (sz == 3'b010) ||
                     (sz == 3'b100) || (sz == 3'b101);
   endfunction

   assign w_req_legal = f_legal(req_we, req_size);

   // Access geometry of the captured request: byte count, lanes, split decision.
   always_comb begin
      w_off = addr_q[1:0];
      case (size_q[1:0])
         2'b00:   begin w_nmask = 4'b0001; w_nbytes = 3'd1; end
         2'b01:   begin w_nmask = 4'b0011; w_nbytes = 3'd2; end
         default: begin w_nmask = 4'b1111; w_nbytes = 3'd4; end
      endcase
      w_two    = ({1'b0, w_off} + w_nbytes) > 3'd4;
      w_last   = beat_q | ~w_two;
      w_mask   = {4'b0000, w_nmask} << w_off;
      w_data64 = {32'h0, wdata_q} << {w_off, 3'b000};
      w_base   = {addr_q[31:2], 2'b00};
   end

   // Load result: merge beat data, shift the addressed bytes down, extend.
   always_comb begin
      w_rd64  = beat_q ? {mem_rdata, rdata0_q} : {32'h0, mem_rdata};
      w_shift = 32'(w_rd64 >> {w_off, 3'b000});
      case (size_q)
         3'b000:  w_ext = {{24{w_shift[7]}}, w_shift[7:0]};
         3'b001:  w_ext = {{16{w_shift[15]}}, w_shift[15:0]};
         3'b100:  w_ext = {24'h0, w_shift[7:0]};
         3'b101:  w_ext = {16'h0, w_shift[15:0]};
         default: w_ext = w_shift;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (req_valid) state_d = w_req_legal ? S_REQ : S_RESP;
         S_REQ:  if (mem_ready) begin
                    if (!we_q)       state_d = S_WAIT;
                    else if (w_last) state_d = S_RESP;
                    else             state_d = S_REQ;
                 end
         S_WAIT: if (mem_rvalid) state_d = w_last ? S_RESP : S_REQ;
         S_RESP: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Request capture, beat sequencing and response data registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q        <= 1'b0;
         size_q      <= 3'b000;
         addr_q      <= 32'h0;
         wdata_q     <= 32'h0;
         beat_q      <= 1'b0;
         rdata0_q    <= 32'h0;
         rsp_rdata_q <= 32'h0;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (req_valid) begin
               we_q    <= req_we;
               size_q  <= req_size;
               addr_q  <= req_addr;
               wdata_q <= req_wdata;
               beat_q  <= 1'b0;
               if (w_req_legal) begin
                  rsp_err_q <= 1'b0;
               end else begin
                  rsp_err_q   <= 1'b1;
                  rsp_rdata_q <= RESP_ERR_DATA;
               end
            end
            S_REQ: if (mem_ready && we_q) begin
               if (w_last) rsp_rdata_q <= 32'h0;
               else        beat_q      <= 1'b1;
            end
            S_WAIT: if (mem_rvalid) begin
               if (w_last) begin
                  rsp_rdata_q <= w_ext;
               end else begin
                  rdata0_q <= mem_rdata;
                  beat_q   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign w_in_req  = (state_q == S_REQ);
   assign req_ready = (state_q == S_IDLE);
   assign rsp_valid = (state_q == S_RESP);
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign mem_valid = w_in_req;
   assign mem_we    = w_in_req & we_q;
   assign mem_addr  = !w_in_req ? 32'h0 : (beat_q ? w_base + 32'd4 : w_base);
   assign mem_be    = !w_in_req ? 4'h0  : (beat_q ? w_mask[7:4] : w_mask[3:0]);
   assign mem_wdata = !w_in_req ? 32'h0 : (beat_q ? w_data64[63:32] : w_data64[31:0]);

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed table-driven bench for load_store_unit with a
//               responsive memory model and hand sequences for stalls/reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_size = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_valid;
   logic        mem_ready = 1'b1;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = 32'h0;

   int checks = 0;
   int errors = 0;

   load_store_unit #(.RESP_ERR_DATA(32'hDEADC0DE)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rd0;
      logic [31:0] rd1;
      int          nb;
      logic [31:0] a0;
      logic [31:0] a1;
      logic [3:0]  be0;
      logic [3:0]  be1;
      logic [31:0] wd0;
      logic [31:0] wd1;
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } vec_t;

   vec_t tbl[11];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic run_vec(input int id, input vec_t v);
      int   nb;
      int   rsp_k;
      logic pend;
      nb = 0; rsp_k = 0; pend = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_ready", id), 32'(req_ready), 32'h1);
      req_valid = 1'b1; req_we = v.we; req_size = v.size;
      req_addr = v.addr; req_wdata = v.wdata;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int k = 1; k <= 20 && rsp_k == 0; k++) begin
         @(negedge clk);
         mem_rvalid = 1'b0;
         if (pend) begin
            mem_rvalid = 1'b1;
            mem_rdata  = (nb == 1) ? v.rd0 : v.rd1;
            pend = 1'b0;
         end
         if (mem_valid) begin
            chk($sformatf("v%0d_b%0d_we", id, nb), 32'(mem_we), 32'(v.we));
            chk($sformatf("v%0d_b%0d_addr", id, nb), mem_addr, (nb == 0) ? v.a0 : v.a1);
            chk($sformatf("v%0d_b%0d_be", id, nb), 32'(mem_be), 32'((nb == 0) ? v.be0 : v.be1));
            if (v.we)
               chk($sformatf("v%0d_b%0d_wdata", id, nb), mem_wdata, (nb == 0) ? v.wd0 : v.wd1);
            nb++;
            if (!v.we) pend = 1'b1;
         end
         if (rsp_valid) begin
            rsp_k = k;
            chk($sformatf("v%0d_rdata", id), rsp_rdata, v.rdata);
            chk($sformatf("v%0d_err", id), 32'(rsp_err), 32'(v.err));
         end
      end
      mem_rvalid = 1'b0;
      chk($sformatf("v%0d_latency", id), rsp_k, v.lat);
      chk($sformatf("v%0d_beats", id), nb, v.nb);
      @(negedge clk);
      chk($sformatf("v%0d_pulse", id), 32'(rsp_valid), 32'h0);
   endtask

   initial begin
      int seen;
      // we size addr wdata rd0 rd1 nb a0 a1 be0 be1 wd0 wd1 rdata err lat
      tbl[0]  = '{1'b0, 3'b010, 32'h100, 32'h0, 32'h11223344, 32'h0, 1,
                  32'h100, 32'h0, 4'b1111, 4'b0000, 32'h0, 32'h0, 32'h11223344, 1'b0, 3};
      tbl[1]  = '{1'b0, 3'b001, 32'h203, 32'h0, 32'hAABBCCDD, 32'h00000080, 2,
                  32'h200, 32'h204, 4'b1000, 4'b0001, 32'h0, 32'h0, 32'hFFFF80AA, 1'b0, 5};
      tbl[2]  = '{1'b1, 3'b010, 32'h102, 32'hCAFEBABE, 32'h0, 32'h0, 2,
                  32'h100, 32'h104, 4'b1100, 4'b0011, 32'hBABE0000, 32'h0000CAFE, 32'h0, 1'b0, 3};
      tbl[3]  = '{1'b0, 3'b100, 32'h1, 32'h0, 32'h0000F000, 32'h0, 1,
                  32'h0, 32'h0, 4'b0010, 4'b0000, 32'h0, 32'h0, 32'h000000F0, 1'b0, 3};
      tbl[4]  = '{1'b0, 3'b000, 32'h1, 32'h0, 32'h0000F000, 32'h0, 1,
                  32'h0, 32'h0, 4'b0010, 4'b0000, 32'h0, 32'h0, 32'hFFFFFFF0, 1'b0, 3};
      tbl[5]  = '{1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 32'h0, 0,
                  32'h0, 32'h0, 4'b0000, 4'b0000, 32'h0, 32'h0, 32'hDEADC0DE, 1'b1, 1};
      tbl[6]  = '{1'b1, 3'b000, 32'h103, 32'h12345678, 32'h0, 32'h0, 1,
                  32'h100, 32'h0, 4'b1000, 4'b0000, 32'h78000000, 32'h0, 32'h0, 1'b0, 2};
      tbl[7]  = '{1'b1, 3'b001, 32'hFFFFFFFF, 32'h0000ABCD, 32'h0, 32'h0, 2,
                  32'hFFFFFFFC, 32'h0, 4'b1000, 4'b0001, 32'hCD000000, 32'h000000AB, 32'h0, 1'b0, 3};
      tbl[8]  = '{1'b1, 3'b100, 32'h100, 32'h55, 32'h0, 32'h0, 0,
                  32'h0, 32'h0, 4'b0000, 4'b0000, 32'h0, 32'h0, 32'hDEADC0DE, 1'b1, 1};
      tbl[9]  = '{1'b0, 3'b101, 32'h2, 32'h0, 32'h80011234, 32'h0, 1,
                  32'h0, 32'h0, 4'b1100, 4'b0000, 32'h0, 32'h0, 32'h00008001, 1'b0, 3};
      tbl[10] = '{1'b0, 3'b010, 32'h1, 32'h0, 32'h44332211, 32'h88776655, 2,
                  32'h0, 32'h4, 4'b1110, 4'b0001, 32'h0, 32'h0, 32'h55443322, 1'b0, 5};

      // Reset values while rst_n is held low.
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'h1);
      chk("rst_mem_valid", 32'(mem_valid), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_be", 32'(mem_be), 32'h0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_rsp_err", 32'(rsp_err), 32'h0);
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++) run_vec(i, tbl[i]);

      // Stalled store beat: mem_* must stay put while mem_ready is low.
      @(negedge clk);
      mem_ready = 1'b0;
      req_valid = 1'b1; req_we = 1'b1; req_size = 3'b010;
      req_addr = 32'h104; req_wdata = 32'h01020304;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("stall%0d_valid", k), 32'(mem_valid), 32'h1);
         chk($sformatf("stall%0d_we", k), 32'(mem_we), 32'h1);
         chk($sformatf("stall%0d_addr", k), mem_addr, 32'h104);
         chk($sformatf("stall%0d_be", k), 32'(mem_be), 32'hF);
         chk($sformatf("stall%0d_wdata", k), mem_wdata, 32'h01020304);
         chk($sformatf("stall%0d_rsp", k), 32'(rsp_valid), 32'h0);
      end
      mem_ready = 1'b1;
      @(negedge clk);
      chk("stall_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("stall_rsp_rdata", rsp_rdata, 32'h0);

      // Reset while waiting for load data; the late rvalid must be ignored.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = 3'b010; req_addr = 32'h100;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("rw_mem_valid", 32'(mem_valid), 32'h1);
      @(negedge clk);
      chk("rw_in_wait", 32'(mem_valid | req_ready), 32'h0);
      rst_n = 1'b0;
      #1;
      chk("rw_rst_ready", 32'(req_ready), 32'h1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      mem_rvalid = 1'b1; mem_rdata = 32'h99999999;
      @(negedge clk);
      mem_rvalid = 1'b0;
      seen = 32'(rsp_valid) + 32'(mem_valid);
      repeat (4) begin
         @(negedge clk);
         seen += 32'(rsp_valid) + 32'(mem_valid);
      end
      chk("rw_no_rsp", seen, 0);
      chk("rw_idle_ready", 32'(req_ready), 32'h1);

      // Unit still usable after the abandoned transaction.
      run_vec(99, tbl[0]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
